calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
Sequencing controller for the keypad calculator datapath. It consumes the one-cycle key events from the keypad interpreter (newhex/hexcode, newop/opcode, eq) and builds hex operands digit by digit. It holds the pending operator, runs the arithmetic (single-cycle add/sub, iterative shift-add multiply) and drives the value shown on the display. It sits between the keypad interpreter and the seven-segment display driver.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
CNT_W, 5, multiply iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
newhex  input  1  one-cycle pulse, hex digit key pressed
hexcode  input  4  digit value, valid with newhex
newop  input  1  one-cycle pulse, operator or equals key pressed
opcode  input  2  00 add, 01 multiply, 10 subtract, 11 treated as add
eq  input  1  one-cycle pulse, equals key pressed (coincides with newop)
display  output  WIDTH  value to show
busy  output  1  high while an operation executes
done  output  1  one-cycle pulse when a result is written
ovf  output  1  arithmetic overflow flag (see Optional Feature)
state_dbg  output  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock domain. Asynchronous, active-low reset: clock and reset_n.
- Registers: acc (WIDTH), entry (WIDTH), pend_op (2), after_eq (1), mul_cnt (CNT_W), mul_mcand/mul_mplier (WIDTH).
- On reset: all registers 0, state S_A, display=0, busy=0, done=0, ovf=0. Reset during S_EXEC aborts the operation. No partial result is kept.
- Event priority in one cycle: eq over newop over newhex. opcode is ignored when eq=1.
- Digit entry: entry <= {entry[WIDTH-5:0], hexcode}. Upper digits are silently discarded once WIDTH/4 digits have been entered.
- States:
  - S_A (entering first operand; display=entry):
    - newhex: shift digit into entry.
    - op: acc<=entry, pend_op<=opcode, entry<=0, go to S_OP.
    - eq: acc<=entry, go to S_RES, pulse done.
  - S_OP (operator held; display=acc):
    - op: replaces pend_op.
    - newhex: entry<=hexcode, go to S_B.
    - eq: go to S_RES, acc unchanged, pulse done.
  - S_B (entering second operand; display=entry):
    - newhex: shift digit into entry.
    - op or eq: capture after_eq=eq and next_op=opcode, go to S_EXEC.
  - S_EXEC (busy=1; display=acc; all key events dropped):
    - add: acc<=acc+entry in the first S_EXEC cycle.
    - sub: acc<=acc-entry (mod 2^WIDTH) in the first S_EXEC cycle.
    - multiply: shift-add over exactly WIDTH cycles. Result is the low WIDTH bits of acc*entry, written in the last cycle.
    - On completion, pulse done and set entry<=0:
      - if after_eq, go to S_RES;
      - else set pend_op<=next_op and go to S_OP (chained operation).
  - S_RES (display=acc):
    - newhex: entry<=hexcode, acc<=0, go to S_A (new calculation).
    - op: result becomes the first operand; pend_op<=opcode, go to S_OP.
    - eq: no effect.
- Latency from the key pulse cycle n:
  - S_EXEC is entered at n+1.
  - add/sub: done is high and acc is updated at n+2.
  - multiply: done is high at n+1+WIDTH.
- busy is high exactly in the cycles spent in S_EXEC.
- done is registered: one cycle only, never two consecutive cycles.

Optional Feature:
CALC_OVF_EN
- Defined:
  - ovf is set on carry-out of add, on borrow of sub (entry>acc), or when any discarded high product bit of a multiply is 1.
  - ovf is sticky and is cleared only by reset or by a digit entered in S_RES.
- Undefined: ovf is tied to 0 and no overflow logic is generated.

Test Plan:
- Digits 1,2,3 then eq → display 0x0123, state S_RES, one done pulse.
- 0x0010 + 0x0005 then eq → S_EXEC entered 1 cycle after eq; done 2 cycles after eq; display 0x0015; busy high exactly 1 cycle.
- 0x0003 × 0x0007 then eq → busy high 16 cycles; display 0x0015. A digit pulse injected mid-EXEC is ignored.
- Chain 5 + 3 × 2 then eq → display 0x0008 after the multiply key, final 0x0010. pend_op is multiply during S_OP.
- 0x0002 − 0x0005 then eq → display 0xFFFD; ovf=1 with CALC_OVF_EN, 0 without. A following digit 4 → display 0x0004, ovf=0.
- reset_n low in cycle 5 of a multiply → immediate busy=0, display=0, state S_A. The next key sequence computes correctly.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Key-event and display bus between the keypad interpreter, the calculator
// sequencer and the seven-segment driver. The master side drives key pulses;
// the slave side (the sequencer) returns the display value and status.
interface calc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             newhex;
  logic [3:0]       hexcode;
  logic             newop;
  logic [1:0]       opcode;
  logic             eq;
  logic [WIDTH-1:0] display;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [2:0]       state_dbg;

  modport master (
    output newhex, hexcode, newop, opcode, eq,
    input  display, busy, done, ovf, state_dbg
  );

  modport slave (
    input  newhex, hexcode, newop, opcode, eq,
    output display, busy, done, ovf, state_dbg
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: builds hex operands, holds the pending operator, runs add/sub/multiply.
// Latency: add/sub result and done 2 cycles after the key pulse; multiply done WIDTH+1 cycles after it.
// Backpressure: none; key events arriving while busy (S_EXEC) are dropped. Optional macro: CALC_OVF_EN.
module calc_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clock,
  input  logic reset_n,
  calc_sequencer_if.slave bus
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_B    = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;

  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_entry;
  logic [1:0]       r_pend_op;
  logic [1:0]       r_next_op;
  logic             r_after_eq;
  logic             r_done;
  logic [CNT_W-1:0] r_mul_cnt;
  logic [WIDTH-1:0] r_mul_mcand;
  logic [WIDTH-1:0] r_mul_mplier;
  logic [WIDTH-1:0] r_mul_hi;

  logic             w_ev_eq;
  logic             w_ev_op;
  logic             w_ev_hex;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_hex_ext;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_is_mul;
  logic             w_is_sub;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi_nxt;
  logic [WIDTH-1:0] w_mul_lo_nxt;
  logic             w_mul_last;
  logic             w_exec_fin;
  logic [WIDTH-1:0] w_exec_res;

  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_entry_nxt;
  logic [1:0]       w_pend_nxt;
  logic [1:0]       w_next_nxt;
  logic             w_after_nxt;
  logic             w_done_set;
  logic             w_mul_start;

  // eq wins over newop, newop wins over newhex
  assign w_ev_eq  = bus.eq;
  assign w_ev_op  = bus.newop & ~bus.eq;
  assign w_ev_hex = bus.newhex & ~bus.newop & ~bus.eq;

  // digit shift drops the top nibble once the entry register is full
  assign w_shift   = {r_entry[WIDTH-5:0], bus.hexcode};
  assign w_hex_ext = {{(WIDTH-4){1'b0}}, bus.hexcode};

  assign w_add = {1'b0, r_acc} + {1'b0, r_entry};
  assign w_sub = {1'b0, r_acc} - {1'b0, r_entry};

  assign w_is_mul = (r_pend_op == OP_MUL);
  assign w_is_sub = (r_pend_op == OP_SUB);

  // Right-shifting multiplier: {hi, mplier} holds the growing 2*WIDTH product,
  // so after WIDTH steps the low half is the result and the high half is what gets discarded.
  assign w_mul_sum    = {1'b0, r_mul_hi} +
                        (r_mul_mplier[0] ? {1'b0, r_mul_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_hi_nxt = w_mul_sum[WIDTH:1];
  assign w_mul_lo_nxt = {w_mul_sum[0], r_mul_mplier[WIDTH-1:1]};
  assign w_mul_last   = (r_mul_cnt == MUL_LAST);

  assign w_exec_fin = (r_state == S_EXEC) & (~w_is_mul | w_mul_last);
  assign w_exec_res = w_is_mul ? w_mul_lo_nxt :
                      w_is_sub ? w_sub[WIDTH-1:0] : w_add[WIDTH-1:0];

  // next-state and register-update decisions for the key-driven sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_entry_nxt = r_entry;
    w_pend_nxt  = r_pend_op;
    w_next_nxt  = r_next_op;
    w_after_nxt = r_after_eq;
    w_done_set  = 1'b0;
    w_mul_start = 1'b0;
    case (r_state)
      S_A: begin
        if (w_ev_eq) begin
          w_acc_nxt   = r_entry;
          w_state_nxt = S_RES;
          w_done_set  = 1'b1;
        end else if (w_ev_op) begin
          w_acc_nxt   = r_entry;
          w_pend_nxt  = bus.opcode;
          w_entry_nxt = '0;
          w_state_nxt = S_OP;
        end else if (w_ev_hex) begin
          w_entry_nxt = w_shift;
        end
      end
      S_OP: begin
        if (w_ev_eq) begin
          w_state_nxt = S_RES;
          w_done_set  = 1'b1;
        end else if (w_ev_op) begin
          w_pend_nxt = bus.opcode;
        end else if (w_ev_hex) begin
          w_entry_nxt = w_hex_ext;
          w_state_nxt = S_B;
        end
      end
      S_B: begin
        if (w_ev_eq | w_ev_op) begin
          w_after_nxt = w_ev_eq;
          w_next_nxt  = bus.opcode;
          w_state_nxt = S_EXEC;
          w_mul_start = 1'b1;
        end else if (w_ev_hex) begin
          w_entry_nxt = w_shift;
        end
      end
      S_EXEC: begin
        if (w_exec_fin) begin
          w_acc_nxt   = w_exec_res;
          w_entry_nxt = '0;
          w_done_set  = 1'b1;
          if (r_after_eq) begin
            w_state_nxt = S_RES;
          end else begin
            w_pend_nxt  = r_next_op;
            w_state_nxt = S_OP;
          end
        end
      end
      S_RES: begin
        if (w_ev_hex) begin
          w_entry_nxt = w_hex_ext;
          w_acc_nxt   = '0;
          w_state_nxt = S_A;
        end else if (w_ev_op) begin
          w_pend_nxt  = bus.opcode;
          w_state_nxt = S_OP;
        end
      end
      default: begin
        w_state_nxt = S_A;
      end
    endcase
  end

  // sequencer state, operands and the done pulse (never high two cycles running)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_A;
      r_acc      <= '0;
      r_entry    <= '0;
      r_pend_op  <= '0;
      r_next_op  <= '0;
      r_after_eq <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_entry    <= w_entry_nxt;
      r_pend_op  <= w_pend_nxt;
      r_next_op  <= w_next_nxt;
      r_after_eq <= w_after_nxt;
      r_done     <= w_done_set & ~r_done;
    end
  end

  // multiply datapath: load operands on entry to S_EXEC, then one shift-add step per cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mul_cnt    <= '0;
      r_mul_mcand  <= '0;
      r_mul_mplier <= '0;
      r_mul_hi     <= '0;
    end else if (w_mul_start) begin
      r_mul_cnt    <= '0;
      r_mul_mcand  <= r_acc;
      r_mul_mplier <= r_entry;
      r_mul_hi     <= '0;
    end else if ((r_state == S_EXEC) && w_is_mul) begin
      r_mul_cnt    <= r_mul_cnt + 1'b1;
      r_mul_mplier <= w_mul_lo_nxt;
      r_mul_hi     <= w_mul_hi_nxt;
    end
  end

`ifdef CALC_OVF_EN
  logic r_ovf;
  logic w_exec_ovf;
  logic w_ovf_clr;

  assign w_exec_ovf = w_is_mul ? (|w_mul_hi_nxt) :
                      w_is_sub ? w_sub[WIDTH] : w_add[WIDTH];
  // a fresh calculation started from the result screen clears the flag
  assign w_ovf_clr  = (r_state == S_RES) & w_ev_hex;

  // sticky overflow: set by any overflowing operation, cleared by a new calculation
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end else if (w_exec_fin && w_exec_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign bus.ovf = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = &{1'b0, w_add[WIDTH], w_sub[WIDTH]};
  assign bus.ovf      = 1'b0;
`endif

  assign bus.display   = ((r_state == S_A) || (r_state == S_B)) ? r_entry : r_acc;
  assign bus.busy      = (r_state == S_EXEC);
  assign bus.done      = r_done;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed keypad scenarios with literal expectations,
// then random key streams, all compared every cycle against an arithmetic model.
module tb_calc_sequencer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam longint unsigned MASK = (64'd1 << WIDTH) - 64'd1;
`ifdef CALC_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam logic [2:0] ST_A    = 3'd0;
  localparam logic [2:0] ST_OP   = 3'd1;
  localparam logic [2:0] ST_B    = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_RES  = 3'd4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  calc_sequencer_if #(.WIDTH(WIDTH)) bus ();

  calc_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]        m_state;
  longint unsigned   m_acc, m_entry, m_res, m_tmp;
  int                m_pend, m_next, m_timer;
  bit                m_after_eq, m_done, m_ovf, m_res_ovf, m_dset;
  bit                ev_eq, ev_op, ev_hex;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state = ST_A; m_acc = 0; m_entry = 0; m_res = 0; m_pend = 0; m_next = 0;
      m_timer = 0; m_after_eq = 0; m_done = 0; m_ovf = 0; m_res_ovf = 0;
    end else begin
      m_dset = 0;
      ev_eq  = bus.eq;
      ev_op  = bus.newop && !bus.eq;
      ev_hex = bus.newhex && !bus.newop && !bus.eq;
      case (m_state)
        ST_A: begin
          if (ev_eq) begin m_acc = m_entry; m_state = ST_RES; m_dset = 1; end
          else if (ev_op) begin m_acc = m_entry; m_pend = int'(bus.opcode); m_entry = 0; m_state = ST_OP; end
          else if (ev_hex) m_entry = ((m_entry << 4) | longint'(bus.hexcode)) & MASK;
        end
        ST_OP: begin
          if (ev_eq) begin m_state = ST_RES; m_dset = 1; end
          else if (ev_op) m_pend = int'(bus.opcode);
          else if (ev_hex) begin m_entry = longint'(bus.hexcode); m_state = ST_B; end
        end
        ST_B: begin
          if (ev_eq || ev_op) begin
            m_after_eq = ev_eq;
            m_next = int'(bus.opcode);
            if (m_pend == 1) begin
              m_tmp = m_acc * m_entry;
              m_res = m_tmp & MASK; m_res_ovf = (m_tmp >> WIDTH) != 0; m_timer = WIDTH;
            end else if (m_pend == 2) begin
              m_res = (m_acc - m_entry) & MASK; m_res_ovf = m_entry > m_acc; m_timer = 1;
            end else begin
              m_tmp = m_acc + m_entry;
              m_res = m_tmp & MASK; m_res_ovf = m_tmp > MASK; m_timer = 1;
            end
            m_state = ST_EXEC;
          end else if (ev_hex) m_entry = ((m_entry << 4) | longint'(bus.hexcode)) & MASK;
        end
        ST_EXEC: begin
          m_timer--;
          if (m_timer == 0) begin
            m_acc = m_res; m_entry = 0; m_dset = 1;
            if (OVF_EN && m_res_ovf) m_ovf = 1;
            if (m_after_eq) m_state = ST_RES;
            else begin m_pend = m_next; m_state = ST_OP; end
          end
        end
        default: begin
          if (ev_hex) begin m_entry = longint'(bus.hexcode); m_acc = 0; m_ovf = 0; m_state = ST_A; end
          else if (ev_op) begin m_pend = int'(bus.opcode); m_state = ST_OP; end
        end
      endcase
      m_done = m_dset && !m_done;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (m_state !== 3'bx) begin
      chk("display", bus.display, (m_state == ST_A || m_state == ST_B) ? m_entry : m_acc);
      chk("busy", bus.busy, m_state == ST_EXEC);
      chk("done", bus.done, m_done);
      chk("ovf", bus.ovf, m_ovf);
      chk("state_dbg", bus.state_dbg, m_state);
      if (bus.busy) busy_cycles++;
      if (bus.done) done_pulses++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic drive(input bit h, input logic [3:0] hc, input bit o, input logic [1:0] oc, input bit e);
    bus.newhex = h; bus.hexcode = hc; bus.newop = o; bus.opcode = oc; bus.eq = e;
    @(negedge clock); #1;
    bus.newhex = 0; bus.hexcode = 0; bus.newop = 0; bus.opcode = 0; bus.eq = 0;
  endtask

  task automatic khex(input logic [3:0] d);
    drive(1, d, 0, 2'b00, 0); idle(1);
  endtask

  task automatic kop(input logic [1:0] c);
    drive(0, 4'h0, 1, c, 0); idle(1);
  endtask

  task automatic keq();
    drive(0, 4'h0, 1, 2'($urandom_range(0, 3)), 1); idle(1);
  endtask

  // waits for the busy phase to end, bounded; returns at the cycle done is visible
  task automatic wait_not_busy(input string name, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin idle(1); n++; end
    if (n >= budget) chk({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.newhex = 0; bus.hexcode = 0; bus.newop = 0; bus.opcode = 0; bus.eq = 0;
    reset_n = 0;
    idle(2);
    chk("rst_display", bus.display, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_state", bus.state_dbg, ST_A);
    reset_n = 1;
    idle(2);

    // digits 1,2,3 then equals
    done_pulses = 0;
    khex(4'h1); khex(4'h2); khex(4'h3);
    keq();
    chk("t1_display", bus.display, 16'h0123);
    chk("t1_state", bus.state_dbg, ST_RES);
    chk("t1_done_pulses", done_pulses, 1);

    // 0x10 + 0x5 with latency checks
    khex(4'h1); khex(4'h0); kop(2'b00); khex(4'h5);
    busy_cycles = 0;
    drive(0, 4'h0, 1, 2'b00, 1);
    chk("t2_exec_entry", bus.state_dbg, ST_EXEC);
    idle(1);
    chk("t2_done_n2", bus.done, 1);
    chk("t2_display", bus.display, 16'h0015);
    idle(2);
    chk("t2_busy_cycles", busy_cycles, 1);

    // 3 x 7 with a digit injected mid-multiply
    khex(4'h3); kop(2'b01); khex(4'h7);
    busy_cycles = 0;
    drive(0, 4'h0, 1, 2'b00, 1);
    idle(3);
    drive(1, 4'h9, 0, 2'b00, 0);
    wait_not_busy("t3", 40);
    chk("t3_done", bus.done, 1);
    chk("t3_display", bus.display, 16'h0015);
    chk("t3_busy_cycles", busy_cycles, WIDTH);
    idle(1);

    // chain 5 + 3 x 2 =
    khex(4'h5); kop(2'b00); khex(4'h3);
    drive(0, 4'h0, 1, 2'b01, 0);
    idle(1);
    chk("t4_partial", bus.display, 16'h0008);
    chk("t4_state_op", bus.state_dbg, ST_OP);
    khex(4'h2); keq();
    wait_not_busy("t4", 40);
    chk("t4_final", bus.display, 16'h0010);
    idle(1);

    // 2 - 5 = wraps, then a new digit clears ovf
    khex(4'h2); kop(2'b10); khex(4'h5); keq();
    wait_not_busy("t5", 10);
    idle(1);
    chk("t5_display", bus.display, 16'hFFFD);
    chk("t5_ovf", bus.ovf, OVF_EN);
    khex(4'h4);
    chk("t5_digit_display", bus.display, 16'h0004);
    chk("t5_digit_ovf", bus.ovf, 0);

    // reset in cycle 5 of a multiply, then a fresh calculation
    kop(2'b01); khex(4'h7);
    drive(0, 4'h0, 1, 2'b00, 1);
    idle(4);
    reset_n = 0;
    #1;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_display", bus.display, 0);
    chk("t6_rst_state", bus.state_dbg, ST_A);
    idle(1);
    reset_n = 1;
    idle(1);
    khex(4'h6); kop(2'b11); khex(4'h9); keq();
    wait_not_busy("t6", 10);
    idle(1);
    chk("t6_after_reset", bus.display, 16'h000F);

    // more digits than fit: upper ones drop out
    khex(4'h1); khex(4'h2); khex(4'h3); khex(4'h4); khex(4'h5);
    chk("t7_discard", bus.display, 16'h2345);
    keq();

    // randomized key streams
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) drive(1, 4'($urandom_range(0, 15)), 0, 2'b00, 0);
      else if (r < 75) drive(0, 4'h0, 1, 2'($urandom_range(0, 3)), 0);
      else if (r < 92) drive(0, 4'h0, 1, 2'($urandom_range(0, 3)), 1);
      else drive(1, 4'($urandom_range(0, 15)), 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      idle($urandom_range(1, 3));
      if ($urandom_range(0, 3) != 0) wait_not_busy("rnd", 40);
      if (i == 250) begin
        reset_n = 0; idle(1); reset_n = 1; idle(1);
      end
    end
    idle(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
